// File: rtl/fault_latch_bank.sv
// fault_latch_bank: per-bit sticky fault latches (level or rising-edge) with a first-event record.
// Define FAULT_LATCH_FILTER_EN to build the consecutive-cycle glitch filter on each input bit.
module fault_latch_bank #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter int unsigned TS_WIDTH      = 32,
    localparam int unsigned IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WIDTH-1:0]    din,
    input  logic [WIDTH-1:0]    mask,
    input  logic [WIDTH-1:0]    edge_mode,
    input  logic [WIDTH-1:0]    clear,
    input  logic                clear_all,
    output logic [WIDTH-1:0]    dout,
    output logic                any,
    output logic                first_valid,
    output logic [IDX_W-1:0]    first_idx,
    output logic [TS_WIDTH-1:0] first_ts
);

    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    q_prev_q, q_prev_d;
    logic [WIDTH-1:0]    latch_q, latch_d;
    logic [WIDTH-1:0]    evt;
    logic [WIDTH-1:0]    clr;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                first_valid_q, first_valid_d;
    logic [IDX_W-1:0]    first_idx_q, first_idx_d;
    logic [TS_WIDTH-1:0] first_ts_q, first_ts_d;
    logic [IDX_W-1:0]    low_idx;
    logic                low_found;
    logic                take_first;

`ifdef FAULT_LATCH_FILTER_EN
    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        q     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
            end
            q[i] = din[i] & (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        q = din;
    end
`endif

    always_comb begin
        q_prev_d = q;
        // Events are gated by reset so dout stays low while resetn is asserted,
        // even for a level-mode bit whose raw input is already high.
        evt = '0;
        if (resetn) begin
            evt = mask & ((edge_mode & q & ~q_prev_q) | (~edge_mode & q));
        end
        clr     = clear_all ? '1 : clear;
        latch_d = (latch_q & ~clr) | evt;
        ts_d    = ts_q + 1'b1;
    end

    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (evt[i] && !low_found) begin
                low_idx   = IDX_W'(i);
                low_found = 1'b1;
            end
        end
    end

    // clear_all re-arms the record in the same cycle, so an event coincident
    // with clear_all becomes the new first event.
    always_comb begin
        take_first    = (!first_valid_q || clear_all) && (evt != '0);
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        first_ts_d    = first_ts_q;
        if (take_first) begin
            first_valid_d = 1'b1;
            first_idx_d   = low_idx;
            first_ts_d    = ts_q;
        end else if (clear_all) begin
            first_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_prev_q      <= '1;
            latch_q       <= '0;
            ts_q          <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_ts_q    <= '0;
        end else begin
            q_prev_q      <= q_prev_d;
            latch_q       <= latch_d;
            ts_q          <= ts_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            first_ts_q    <= first_ts_d;
        end
    end

    always_comb begin
        dout        = latch_q | evt;
        any         = |dout;
        first_valid = first_valid_q;
        first_idx   = first_idx_q;
        first_ts    = first_ts_q;
    end

endmodule

// File: tb/tb_fault_latch_bank.sv
// Directed scoreboard bench for fault_latch_bank (WIDTH=8, TS_WIDTH=8) plus a filtered instance.
module tb_fault_latch_bank;
    localparam int unsigned W = 8;
`ifdef FAULT_LATCH_FILTER_EN
    localparam int unsigned FLT_N = 3;
`else
    localparam int unsigned FLT_N = 1;
`endif
    localparam logic FLT_PASS1 = (FLT_N == 1) ? 1'b1 : 1'b0;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] din, mask, edge_mode, clear;
    logic         clear_all;
    logic [W-1:0] dout;
    logic         any, first_valid;
    logic [2:0]   first_idx;
    logic [7:0]   first_ts;

    logic [W-1:0] fdin, fdout;
    logic         fclr, fany, fvalid;
    logic [2:0]   fidx;
    logic [7:0]   fts;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ev_ts, ts2, ts3, ts4;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fault_latch_bank #(.WIDTH(W), .FILTER_CYCLES(1), .TS_WIDTH(8)) u_dut (
        .clk(clk), .resetn(resetn), .din(din), .mask(mask), .edge_mode(edge_mode),
        .clear(clear), .clear_all(clear_all), .dout(dout), .any(any),
        .first_valid(first_valid), .first_idx(first_idx), .first_ts(first_ts)
    );

    fault_latch_bank #(.WIDTH(W), .FILTER_CYCLES(3), .TS_WIDTH(8)) u_flt (
        .clk(clk), .resetn(resetn), .din(fdin), .mask(8'hFF), .edge_mode(8'h00),
        .clear(8'h00), .clear_all(fclr), .dout(fdout), .any(fany),
        .first_valid(fvalid), .first_idx(fidx), .first_ts(fts)
    );

    task automatic expect_val(input string tag, input logic [63:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic cyc_step(input logic [7:0] m, input logic [7:0] d, input logic [7:0] clr,
                            input logic ca, input logic [7:0] exp_dout, input string tag);
        @(negedge clk);
        cyc++;
        mask = m; din = d; clear = clr; clear_all = ca;
        expect_val({tag, "_dout"}, 64'(exp_dout));
        expect_val({tag, "_any"}, 64'(|exp_dout));
        #1;
        check(64'(dout));
        check(64'(any));
    endtask

    task automatic chk_first(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] ts);
        expect_val({tag, "_valid"}, 64'(v));
        expect_val({tag, "_idx"}, 64'(idx));
        expect_val({tag, "_ts"}, 64'(ts));
        check(64'(first_valid));
        check(64'(first_idx));
        check(64'(first_ts));
    endtask

    task automatic fstep(input logic d, input logic ca, input logic e, input string tag);
        @(negedge clk);
        cyc++;
        fdin = {7'b0, d};
        fclr = ca;
        expect_val(tag, 64'(e));
        #1;
        check(64'(fdout[0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; din = 8'h02; mask = 8'hFF; edge_mode = 8'h02;
        clear = '0; clear_all = 1'b0; fdin = '0; fclr = 1'b0;
        #12;
        expect_val("rst_dout", 64'h0);
        expect_val("rst_any", 64'h0);
        check(64'(dout));
        check(64'(any));
        chk_first("rst", 1'b0, 3'd0, 8'd0);

        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        expect_val("edge_held_at_release", 64'h0);
        #1;
        check(64'(dout));

        cyc_step(8'hFF, 8'h06, 8'h00, 1'b0, 8'h04, "lvl_set");
        ev_ts = cyc;
        cyc_step(8'hFF, 8'h02, 8'h00, 1'b0, 8'h04, "lvl_hold");
        chk_first("lvl_rec", 1'b1, 3'd2, 8'(ev_ts));
        cyc_step(8'hFF, 8'h00, 8'h00, 1'b0, 8'h04, "edge_low");
        cyc_step(8'hFF, 8'h02, 8'h00, 1'b0, 8'h06, "edge_rise");
        chk_first("edge_rec", 1'b1, 3'd2, 8'(ev_ts));
        cyc_step(8'hFF, 8'h02, 8'h02, 1'b0, 8'h06, "edge_clr");
        cyc_step(8'hFF, 8'h02, 8'h00, 1'b0, 8'h04, "edge_stay");
        chk_first("clr_rec", 1'b1, 3'd2, 8'(ev_ts));

        cyc_step(8'hFF, 8'h01, 8'h00, 1'b1, 8'h05, "ca_ev");
        ts2 = cyc;
        cyc_step(8'hFF, 8'h02, 8'h00, 1'b0, 8'h03, "two_set");
        chk_first("ca_rec", 1'b1, 3'd0, 8'(ts2));
        cyc_step(8'hFF, 8'h01, 8'h01, 1'b0, 8'h03, "set_beats_clr");
        cyc_step(8'hFF, 8'h00, 8'h01, 1'b0, 8'h03, "clr_pend");
        cyc_step(8'hFF, 8'h00, 8'h00, 1'b0, 8'h02, "clr_done");
        chk_first("clr_keep", 1'b1, 3'd0, 8'(ts2));

        cyc_step(8'hFF, 8'h00, 8'h00, 1'b1, 8'h02, "ca_none");
        cyc_step(8'hFF, 8'h30, 8'h00, 1'b0, 8'h30, "multi");
        chk_first("ca_invalid", 1'b0, 3'd0, 8'(ts2));
        ts3 = cyc;
        cyc_step(8'hFF, 8'h01, 8'h00, 1'b0, 8'h31, "later");
        chk_first("multi_rec", 1'b1, 3'd4, 8'(ts3));
        cyc_step(8'hFF, 8'h00, 8'h00, 1'b0, 8'h31, "later_hold");
        chk_first("later_rec", 1'b1, 3'd4, 8'(ts3));
        cyc_step(8'hFF, 8'h80, 8'h00, 1'b1, 8'hB1, "ca_same");
        ts4 = cyc;
        cyc_step(8'hFF, 8'h00, 8'h00, 1'b0, 8'h80, "ca_same_hold");
        chk_first("ca_same_rec", 1'b1, 3'd7, 8'(ts4));

        cyc_step(8'hDF, 8'h20, 8'h00, 1'b0, 8'h80, "mask_block");
        cyc_step(8'h5F, 8'h00, 8'h00, 1'b0, 8'h80, "mask_keep");
        cyc_step(8'hFF, 8'h01, 8'h00, 1'b0, 8'h81, "pre_rst");

        @(posedge clk);
        #2;
        resetn = 1'b0;
        expect_val("arst_dout", 64'h0);
        expect_val("arst_any", 64'h0);
        #1;
        check(64'(dout));
        check(64'(any));
        chk_first("arst", 1'b0, 3'd0, 8'd0);

        @(negedge clk);
        din = '0;
        resetn = 1'b1;
        cyc = 0;

        fstep(1'b1, 1'b0, FLT_PASS1, "flt_p2_a");
        fstep(1'b1, 1'b0, FLT_PASS1, "flt_p2_b");
        fstep(1'b0, 1'b0, FLT_PASS1, "flt_p2_after");
        fstep(1'b0, 1'b1, FLT_PASS1, "flt_clear");
        fstep(1'b1, 1'b0, FLT_PASS1, "flt_p3_a");
        fstep(1'b1, 1'b0, FLT_PASS1, "flt_p3_b");
        fstep(1'b1, 1'b0, 1'b1, "flt_p3_c");
        fstep(1'b0, 1'b0, 1'b1, "flt_p3_hold");

        while (cyc < 254) begin
            @(negedge clk);
            cyc++;
        end
        cyc_step(8'hFF, 8'h01, 8'h00, 1'b0, 8'h01, "ts_max");
        cyc_step(8'hFF, 8'h02, 8'h00, 1'b1, 8'h03, "ts_wrap");
        chk_first("ts_ff", 1'b1, 3'd0, 8'hFF);
        cyc_step(8'hFF, 8'h00, 8'h00, 1'b0, 8'h02, "ts_after");
        chk_first("ts_wrap_rec", 1'b1, 3'd1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
